bus_arbiter: RTL and testbench

- Single-port memory arbiter between the instruction-fetch path (pc_reg/if_id side) and the data-access path (mem stage) of the 5-stage pipeline.
- Both requesters share one SRAM-like bus, and each access takes a programmable number of wait cycles.
- Grants one requester at a time with fixed data priority, latches the request, sequences the access, returns read data with a one-cycle ack pulse, and raises a pipeline stall request while any requester is waiting.

---
 rtl/bus_arbiter_if.sv | 49 ++++
 rtl/bus_arbiter.sv | 111 +++++++++++
 tb/tb_bus_arbiter.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_if.sv
// Shared-bus arbiter port bundle: fetch side, data side and SRAM-like bus.
// The arbiter takes the slave view; requesters and the bus model take master.
interface bus_arbiter_if;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_data_o;
    logic        if_ack_o;

    logic        mem_req_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_rdata_o;
    logic        mem_ack_o;

    logic        bus_ce_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_rdata_i;

    logic        stallreq_o;

    modport slave (
        input  if_req_i, if_addr_i,
        output if_data_o, if_ack_o,
        input  mem_req_i, mem_we_i, mem_addr_i,
        input  mem_wdata_i, mem_sel_i,
        output mem_rdata_o, mem_ack_o,
        output bus_ce_o, bus_we_o, bus_addr_o,
        output bus_wdata_o, bus_sel_o,
        input  bus_rdata_i,
        output stallreq_o
    );

    modport master (
        output if_req_i, if_addr_i,
        input  if_data_o, if_ack_o,
        output mem_req_i, mem_we_i, mem_addr_i,
        output mem_wdata_i, mem_sel_i,
        input  mem_rdata_o, mem_ack_o,
        input  bus_ce_o, bus_we_o, bus_addr_o,
        input  bus_wdata_o, bus_sel_o,
        output bus_rdata_i,
        input  stallreq_o
    );
endinterface

// File: rtl/bus_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access.
// Data has fixed priority; each access holds the bus for WAIT_CYCLES cycles.
module bus_arbiter #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    bus_arbiter_if.slave arb
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        I_ACC = 2'd1,
        D_ACC = 2'd2
    } state_t;

    localparam logic [3:0] LOAD = 4'(WAIT_CYCLES - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic        ce_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  sel_q;
    logic [31:0] if_data_q;
    logic [31:0] mem_rdata_q;
    logic        if_ack_q;
    logic        mem_ack_q;
    logic        if_pend;
    logic        mem_pend;

    // Requests acked this cycle are masked so they are not re-granted.
    assign if_pend  = arb.if_req_i & ~if_ack_q;
    assign mem_pend = arb.mem_req_i & ~mem_ack_q;

    // Stall the pipeline whenever any requester is still waiting.
    assign arb.stallreq_o = if_pend | mem_pend;

    assign arb.bus_ce_o    = ce_q;
    assign arb.bus_we_o    = we_q;
    assign arb.bus_addr_o  = addr_q;
    assign arb.bus_wdata_o = wdata_q;
    assign arb.bus_sel_o   = sel_q;
    assign arb.if_data_o   = if_data_q;
    assign arb.if_ack_o    = if_ack_q;
    assign arb.mem_rdata_o = mem_rdata_q;
    assign arb.mem_ack_o   = mem_ack_q;

    // Arbitration and access sequencing; all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            ce_q        <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            sel_q       <= 4'd0;
            if_data_q   <= 32'd0;
            mem_rdata_q <= 32'd0;
            if_ack_q    <= 1'b0;
            mem_ack_q   <= 1'b0;
        end else begin
            if_ack_q  <= 1'b0;
            mem_ack_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (mem_pend) begin
                        state   <= D_ACC;
                        ce_q    <= 1'b1;
                        we_q    <= arb.mem_we_i;
                        addr_q  <= arb.mem_addr_i;
                        wdata_q <= arb.mem_wdata_i;
                        sel_q   <= arb.mem_sel_i;
                        cnt     <= LOAD;
                    end else if (if_pend) begin
                        state   <= I_ACC;
                        ce_q    <= 1'b1;
                        we_q    <= 1'b0;
                        addr_q  <= arb.if_addr_i;
                        wdata_q <= 32'd0;
                        sel_q   <= 4'hF;
                        cnt     <= LOAD;
                    end
                end
                I_ACC, D_ACC: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (state == I_ACC) begin
                            if_data_q <= arb.bus_rdata_i;
                            if_ack_q  <= 1'b1;
                        end else begin
                            if (!we_q) begin
                                mem_rdata_q <= arb.bus_rdata_i;
                            end
                            mem_ack_q <= 1'b1;
                        end
                        ce_q  <= 1'b0;
                        we_q  <= 1'b0;
                        sel_q <= 4'd0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: one DUT at WAIT_CYCLES=2, one at 1.
// Cycle c counts clock periods from the cycle a request is first raised.
module tb_bus_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vecs = 0;
    int   errs = 0;

    always #5 clk = ~clk;

    bus_arbiter_if ia ();
    bus_arbiter_if ib ();

    bus_arbiter #(.WAIT_CYCLES(2)) dut_a (
        .clk (clk),
        .rst (rst),
        .arb (ia.slave)
    );

    bus_arbiter #(.WAIT_CYCLES(1)) dut_b (
        .clk (clk),
        .rst (rst),
        .arb (ib.slave)
    );

    task automatic idle_inputs();
        ia.if_req_i = 0; ia.if_addr_i = 0;
        ia.mem_req_i = 0; ia.mem_we_i = 0;
        ia.mem_addr_i = 0; ia.mem_wdata_i = 0;
        ia.mem_sel_i = 0; ia.bus_rdata_i = 0;
        ib.if_req_i = 0; ib.if_addr_i = 0;
        ib.mem_req_i = 0; ib.mem_we_i = 0;
        ib.mem_addr_i = 0; ib.mem_wdata_i = 0;
        ib.mem_sel_i = 0; ib.bus_rdata_i = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        #2;
        vecs++; if (ia.bus_ce_o !== 1'b0) begin errs++; $display("FAIL rst_ce got %b want 0", ia.bus_ce_o); end
        vecs++; if (ia.bus_addr_o !== 32'd0) begin errs++; $display("FAIL rst_addr got %h want 0", ia.bus_addr_o); end
        vecs++; if (ia.bus_sel_o !== 4'd0) begin errs++; $display("FAIL rst_sel got %h want 0", ia.bus_sel_o); end
        vecs++; if (ia.bus_we_o !== 1'b0) begin errs++; $display("FAIL rst_we got %b want 0", ia.bus_we_o); end
        vecs++; if (ia.if_ack_o !== 1'b0 || ia.mem_ack_o !== 1'b0) begin errs++; $display("FAIL rst_ack got %b%b want 00", ia.if_ack_o, ia.mem_ack_o); end
        vecs++; if (ia.if_data_o !== 32'd0 || ia.mem_rdata_o !== 32'd0) begin errs++; $display("FAIL rst_data got %h %h want 0 0", ia.if_data_o, ia.mem_rdata_o); end
        vecs++; if (ia.stallreq_o !== 1'b0) begin errs++; $display("FAIL rst_stall got %b want 0", ia.stallreq_o); end
        vecs++; if (ib.bus_ce_o !== 1'b0 || ib.if_ack_o !== 1'b0) begin errs++; $display("FAIL rst_b got %b%b want 00", ib.bus_ce_o, ib.if_ack_o); end
        @(negedge clk);
        rst = 0;
        next_cycle();
    endtask

    task automatic test_fetch();
        logic [3:0] e_ce = 4'b0110;
        logic [3:0] e_ack = 4'b1000;
        logic [3:0] e_st = 4'b0111;
        ia.if_addr_i = 32'h10;
        ia.if_req_i = 1;
        ia.bus_rdata_i = 32'h0;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) ia.bus_rdata_i = 32'h34011100;
            if (c == 3) ia.bus_rdata_i = 32'h0;
            #1;
            if (c < 4) begin
                vecs++; if (ia.bus_ce_o !== e_ce[c]) begin errs++; $display("FAIL fetch_ce c%0d got %b want %b", c, ia.bus_ce_o, e_ce[c]); end
                vecs++; if (ia.if_ack_o !== e_ack[c]) begin errs++; $display("FAIL fetch_ack c%0d got %b want %b", c, ia.if_ack_o, e_ack[c]); end
                vecs++; if (ia.stallreq_o !== e_st[c]) begin errs++; $display("FAIL fetch_stall c%0d got %b want %b", c, ia.stallreq_o, e_st[c]); end
            end
            if (c == 1 || c == 2) begin
                vecs++; if (ia.bus_addr_o !== 32'h10) begin errs++; $display("FAIL fetch_addr c%0d got %h want 00000010", c, ia.bus_addr_o); end
                vecs++; if (ia.bus_we_o !== 1'b0) begin errs++; $display("FAIL fetch_we c%0d got %b want 0", c, ia.bus_we_o); end
                vecs++; if (ia.bus_sel_o !== 4'hF) begin errs++; $display("FAIL fetch_sel c%0d got %h want f", c, ia.bus_sel_o); end
            end
            if (c == 3) begin
                vecs++; if (ia.if_data_o !== 32'h34011100) begin errs++; $display("FAIL fetch_data got %h want 34011100", ia.if_data_o); end
                ia.if_req_i = 0;
            end
            if (c == 4) begin
                vecs++; if (ia.bus_ce_o !== 1'b0 || ia.if_ack_o !== 1'b0) begin errs++; $display("FAIL fetch_idle got %b%b want 00", ia.bus_ce_o, ia.if_ack_o); end
                vecs++; if (ia.bus_sel_o !== 4'd0) begin errs++; $display("FAIL fetch_selclr got %h want 0", ia.bus_sel_o); end
            end
            next_cycle();
        end
    endtask

    task automatic test_priority();
        logic [7:0] e_ce = 8'b0011_0110;
        logic [7:0] e_mack = 8'b0000_1000;
        logic [7:0] e_iack = 8'b0100_0000;
        logic [7:0] e_st = 8'b0011_1111;
        ia.if_addr_i = 32'h20;
        ia.mem_addr_i = 32'h100;
        ia.mem_we_i = 0;
        ia.mem_sel_i = 4'hF;
        ia.if_req_i = 1;
        ia.mem_req_i = 1;
        for (int c = 0; c < 8; c++) begin
            ia.bus_rdata_i = (c == 2) ? 32'hDEADBEEF :
                             (c == 5) ? 32'h11112222 : 32'h0;
            #1;
            vecs++; if (ia.bus_ce_o !== e_ce[c]) begin errs++; $display("FAIL prio_ce c%0d got %b want %b", c, ia.bus_ce_o, e_ce[c]); end
            vecs++; if (ia.mem_ack_o !== e_mack[c]) begin errs++; $display("FAIL prio_mack c%0d got %b want %b", c, ia.mem_ack_o, e_mack[c]); end
            vecs++; if (ia.if_ack_o !== e_iack[c]) begin errs++; $display("FAIL prio_iack c%0d got %b want %b", c, ia.if_ack_o, e_iack[c]); end
            vecs++; if (ia.stallreq_o !== e_st[c]) begin errs++; $display("FAIL prio_stall c%0d got %b want %b", c, ia.stallreq_o, e_st[c]); end
            if (c == 1) begin
                vecs++; if (ia.bus_addr_o !== 32'h100) begin errs++; $display("FAIL prio_daddr got %h want 00000100", ia.bus_addr_o); end
            end
            if (c == 4) begin
                vecs++; if (ia.bus_addr_o !== 32'h20) begin errs++; $display("FAIL prio_iaddr got %h want 00000020", ia.bus_addr_o); end
            end
            if (c == 3) begin
                vecs++; if (ia.mem_rdata_o !== 32'hDEADBEEF) begin errs++; $display("FAIL prio_rdata got %h want deadbeef", ia.mem_rdata_o); end
                ia.mem_req_i = 0;
            end
            if (c == 6) begin
                vecs++; if (ia.if_data_o !== 32'h11112222) begin errs++; $display("FAIL prio_idata got %h want 11112222", ia.if_data_o); end
                ia.if_req_i = 0;
            end
            next_cycle();
        end
    endtask

    task automatic test_write();
        ia.mem_addr_i = 32'h200;
        ia.mem_wdata_i = 32'hA5A5A5A5;
        ia.mem_sel_i = 4'h3;
        ia.mem_we_i = 1;
        ia.mem_req_i = 1;
        for (int c = 0; c < 4; c++) begin
            ia.bus_rdata_i = (c == 2) ? 32'h0BADF00D : 32'h0;
            #1;
            if (c == 1 || c == 2) begin
                vecs++; if (ia.bus_ce_o !== 1'b1 || ia.bus_we_o !== 1'b1) begin errs++; $display("FAIL wr_cewe c%0d got %b%b want 11", c, ia.bus_ce_o, ia.bus_we_o); end
                vecs++; if (ia.bus_sel_o !== 4'h3) begin errs++; $display("FAIL wr_sel c%0d got %h want 3", c, ia.bus_sel_o); end
                vecs++; if (ia.bus_wdata_o !== 32'hA5A5A5A5) begin errs++; $display("FAIL wr_wdata c%0d got %h want a5a5a5a5", c, ia.bus_wdata_o); end
                vecs++; if (ia.bus_addr_o !== 32'h200) begin errs++; $display("FAIL wr_addr c%0d got %h want 00000200", c, ia.bus_addr_o); end
            end
            if (c == 3) begin
                vecs++; if (ia.mem_ack_o !== 1'b1) begin errs++; $display("FAIL wr_ack got %b want 1", ia.mem_ack_o); end
                vecs++; if (ia.bus_ce_o !== 1'b0 || ia.bus_we_o !== 1'b0) begin errs++; $display("FAIL wr_clr got %b%b want 00", ia.bus_ce_o, ia.bus_we_o); end
                vecs++; if (ia.mem_rdata_o !== 32'hDEADBEEF) begin errs++; $display("FAIL wr_rdata got %h want deadbeef", ia.mem_rdata_o); end
                ia.mem_req_i = 0;
                ia.mem_we_i = 0;
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid();
        logic [6:0] e_ce = 7'b011_0110;
        logic [6:0] e_ack = 7'b100_0000;
        ia.if_addr_i = 32'h40;
        ia.if_req_i = 1;
        for (int c = 0; c < 7; c++) begin
            ia.bus_rdata_i = (c == 2) ? 32'hCAFEF00D :
                             (c == 5) ? 32'h00000055 : 32'h0;
            rst = (c == 2);
            #1;
            vecs++; if (ia.bus_ce_o !== e_ce[c]) begin errs++; $display("FAIL rstm_ce c%0d got %b want %b", c, ia.bus_ce_o, e_ce[c]); end
            vecs++; if (ia.if_ack_o !== e_ack[c]) begin errs++; $display("FAIL rstm_ack c%0d got %b want %b", c, ia.if_ack_o, e_ack[c]); end
            if (c == 3) begin
                vecs++; if (ia.if_data_o !== 32'd0) begin errs++; $display("FAIL rstm_data got %h want 0", ia.if_data_o); end
                vecs++; if (ia.stallreq_o !== 1'b1) begin errs++; $display("FAIL rstm_stall got %b want 1", ia.stallreq_o); end
            end
            if (c == 6) begin
                vecs++; if (ia.if_data_o !== 32'h55) begin errs++; $display("FAIL rstm_redo got %h want 00000055", ia.if_data_o); end
                ia.if_req_i = 0;
            end
            next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] e_ce = 6'b01_0010;
        logic [5:0] e_ack = 6'b10_0100;
        int first_ack = -1;
        int gap = -1;
        ib.if_addr_i = 32'h0;
        ib.if_req_i = 1;
        for (int c = 0; c < 6; c++) begin
            ib.bus_rdata_i = (c == 1) ? 32'hA0 : (c == 4) ? 32'hA4 : 32'h0;
            if (c == 4) ib.if_addr_i = 32'h8;
            #1;
            vecs++; if (ib.bus_ce_o !== e_ce[c]) begin errs++; $display("FAIL b2b_ce c%0d got %b want %b", c, ib.bus_ce_o, e_ce[c]); end
            vecs++; if (ib.if_ack_o !== e_ack[c]) begin errs++; $display("FAIL b2b_ack c%0d got %b want %b", c, ib.if_ack_o, e_ack[c]); end
            vecs++; if (ib.if_ack_o === 1'b1 && ib.bus_ce_o !== 1'b0) begin errs++; $display("FAIL b2b_ce_in_ack c%0d got %b want 0", c, ib.bus_ce_o); end
            if (ib.if_ack_o === 1'b1) begin
                if (first_ack < 0) first_ack = c;
                else gap = c - first_ack;
            end
            if (c == 1) begin
                vecs++; if (ib.bus_addr_o !== 32'h0) begin errs++; $display("FAIL b2b_addr0 got %h want 0", ib.bus_addr_o); end
            end
            if (c == 2) begin
                vecs++; if (ib.if_data_o !== 32'hA0) begin errs++; $display("FAIL b2b_data0 got %h want 000000a0", ib.if_data_o); end
                ib.if_addr_i = 32'h4;
            end
            if (c == 4) begin
                vecs++; if (ib.bus_addr_o !== 32'h4) begin errs++; $display("FAIL b2b_addr4 got %h want 00000004", ib.bus_addr_o); end
            end
            if (c == 5) begin
                vecs++; if (ib.if_data_o !== 32'hA4) begin errs++; $display("FAIL b2b_data4 got %h want 000000a4", ib.if_data_o); end
                ib.if_req_i = 0;
            end
            next_cycle();
        end
        vecs++; if (gap !== 3) begin errs++; $display("FAIL b2b_gap got %0d want 3", gap); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_fetch();
        test_priority();
        test_write();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
